// File: rtl/sid_bus_responder.sv
// SID register-bus target: synchronises the async bus, shadows writes,
// answers reads, reports 25-register frames and bus inactivity.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   phi2, cs_n, rw,     async SID bus (phi2 clock, select, direction,
//   addr, data_in,      address, write data, bus reset)
//   sid_rst_n
//   data_out, data_oe   read data and its drive enable
//   rd_addr, rd_data    debug shadow readback (combinational)
//   wr_strobe, wr_addr, wr_data   captured-write report
//   frame_done, frame_ok, frame_cnt   frame completion report
//   bus_idle            no phi2 edge for TIMEOUT_CYC cycles
module sid_bus_responder #(
  parameter logic [7:0] POT_VAL = 8'h80,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi2,
  input  logic        cs_n,
  input  logic        rw,
  input  logic [4:0]  addr,
  input  logic [7:0]  data_in,
  input  logic        sid_rst_n,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_cnt,
  output logic        bus_idle
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);
  localparam logic [16:0] SYNC_RST = {1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 8'd0};

  typedef enum logic [1:0] {
    S_LOW,
    S_HIGH_IDLE,
    S_HIGH_WR,
    S_HIGH_RD
  } state_t;

  logic [16:0] sync0, sync1;
  logic        srst_s, phi2_s, cs_s, rw_s;
  logic [4:0]  addr_s;
  logic [7:0]  data_s;
  logic        phi2_d, rise, fall, commit;
  state_t      state_q, state_d;
  logic [7:0]  shadow [0:24];
  logic [24:0] mask;
  logic [TW-1:0] tcnt;
  logic [7:0]  rd_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0  <= SYNC_RST;
      sync1  <= SYNC_RST;
      phi2_d <= 1'b0;
    end else begin
      sync0  <= {sid_rst_n, phi2, cs_n, rw, addr, data_in};
      sync1  <= sync0;
      phi2_d <= phi2_s;
    end
  end

  assign {srst_s, phi2_s, cs_s, rw_s, addr_s, data_s} = sync1;
  assign rise = phi2_s & ~phi2_d;
  assign fall = ~phi2_s & phi2_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LOW;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOW: begin
        if (rise) begin
          if (cs_s)      state_d = S_HIGH_IDLE;
          else if (rw_s) state_d = S_HIGH_RD;
          else           state_d = S_HIGH_WR;
        end
      end
      default: begin
        if (fall) state_d = S_LOW;
      end
    endcase
    if (!srst_s) state_d = S_LOW;
  end

  assign commit = fall & (state_q == S_HIGH_WR) & ~cs_s & srst_s;

  // Regs 0..24 read back from the shadow so the bench can see writes.
  always_comb begin
    rd_val = 8'hFF;
    if (addr_s <= 5'd24)                      rd_val = shadow[addr_s];
    else if (addr_s == 5'd25 || addr_s == 5'd26) rd_val = POT_VAL;
    else if (addr_s == 5'd27 || addr_s == 5'd28) rd_val = 8'h00;
  end

  // Drive is released combinationally in the cycle the fall is seen.
  assign data_oe  = (state_q == S_HIGH_RD) & ~fall & srst_s;
  assign data_out = data_oe ? rd_val : 8'h00;
  assign rd_data  = (rd_addr <= 5'd24) ? shadow[rd_addr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst || !srst_s) begin
      for (int i = 0; i < 25; i++) shadow[i] <= 8'h00;
      mask <= '0;
    end else if (commit && addr_s <= 5'd24) begin
      shadow[addr_s] <= data_s;
      if (addr_s == 5'd24) mask <= '0;
      else                 mask[addr_s] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_strobe  <= 1'b0;
      wr_addr    <= 5'd0;
      wr_data    <= 8'h00;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      wr_strobe  <= commit;
      frame_done <= commit && addr_s == 5'd24;
      if (commit) begin
        wr_addr <= addr_s;
        wr_data <= data_s;
      end
      if (commit && addr_s == 5'd24) begin
        frame_ok  <= &(mask | (25'd1 << 24));
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               tcnt <= '0;
    else if (rise || fall) tcnt <= '0;
    else if (tcnt != TMAX) tcnt <= tcnt + 1'b1;
  end

  assign bus_idle = (tcnt == TMAX);

endmodule
